dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-port data memory between the RISC-V core and an external master (loader/debug DMA). It sits between `riscv`'s data bus and `dmem`. Each cycle it grants at most one requester, supports round-robin fairness and a bounded external lock, and stalls the core while the memory is owned elsewhere.

## Interface
- `MAX_LOCK`, default 8: consecutive locked external grants allowed while the core is waiting (1..255).
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cpu_req`  in  1  core access request (load or store)
- `cpu_we`  in  1  core store enable
- `cpu_addr`, `cpu_wdata`  in  32 each  core address / store data
- `cpu_rdata`  out  32  load data to core
- `cpu_stall`  out  1  core must hold its instruction
- `ext_req`, `ext_we`, `ext_lock`  in  1 each  external request / write / keep-ownership hint
- `ext_addr`, `ext_wdata`  in  32 each  external address / write data
- `ext_gnt`  out  1  external access performed this cycle
- `ext_rdata`  out  32  read data to external master
- `mem_we`  out  1  to `dmem` write enable
- `mem_addr`, `mem_wdata`  out  32 each  to `dmem`
- `mem_rdata`  in  32  from `dmem` (combinational read)

## Operation
- State: `st` ∈ {IDLE, LOCKED}; `last` (0 = core, 1 = ext) holds the most recent owner; `lock_cnt` is 8 bits.
- Grant (combinational from state and requests):
  - IDLE, single requester: grant it.
  - IDLE, both requesting: grant the one that is not `last`.
  - LOCKED: grant ext if `ext_req`. If `cpu_req` and `lock_cnt == MAX_LOCK`, grant the core instead (forced break).
  - LOCKED with `ext_req` low: grant core if `cpu_req`.
- Muxing: the granted side drives `mem_addr`/`mem_wdata`. `mem_we = granted_we`. With no grant, `mem_*` = 0.
- `cpu_rdata` and `ext_rdata` both equal `mem_rdata`. They are valid only in the requester's granted cycle.
- `cpu_stall = cpu_req & ~cpu_gnt`.
- State transitions (posedge):
  - IDLE→LOCKED when `ext_gnt & ext_lock`.
  - LOCKED→IDLE when any of: ext granted with `ext_lock` low; `ext_req` low; core granted (forced break).
  - `last` updates on every grant.
  - `lock_cnt` clears on entering or leaving LOCKED and when `cpu_req` is low. It increments, saturating, on each LOCKED ext grant while `cpu_req` is high.
- After a forced break the core gets exactly one grant. Normal IDLE arbitration then resumes, and ext may re-lock.
- Reset (asynchronous, any time, including mid-lock): `st`=IDLE, `last`=1 so the core wins the first contest, `lock_cnt`=0. While `reset` is high, `cpu_gnt`, `ext_gnt`, `mem_we` and `cpu_stall` are 0 and `mem_addr`/`mem_wdata` are 0.

## Timing
- Zero-cycle arbitration: grant, mux and read data are combinational in the request cycle.
- A store commits at the rising edge ending its granted cycle.
- A stalled requester must hold its request fields stable until granted. `ext_gnt` is the external completion strobe.
- Worst-case core wait under contention without lock: 1 cycle. With lock: `MAX_LOCK` cycles.
- Worst-case ext wait: 1 cycle, because round-robin alternates.
- Back-to-back grants to the same requester are allowed when the other side is not requesting.

## Test plan
- Reset, then core-only load at 0x10 with `mem_rdata`=0xDEADBEEF → `cpu_gnt` path active, `cpu_rdata`=0xDEADBEEF, `cpu_stall`=0, `ext_gnt`=0.
- Both request (no lock) for 4 cycles → grants alternate core, ext, core, ext. `cpu_stall` is high in cycles 2 and 4. Ext store of 0x55 to 0x20 drives `mem_we`=1, `mem_addr`=0x20 only in cycle 2.
- Ext lock with `MAX_LOCK`=3 and core requesting continuously → ext granted 3 locked cycles, core granted on cycle 5 (forced break), then IDLE round-robin.
- Ext locked, then drops `ext_lock` on a granted cycle → next cycle IDLE. A pending core request is granted immediately.
- Assert `reset` while LOCKED with `mem_we`=1 → `mem_we`, grants and stall go to 0 asynchronously. After release, a simultaneous request is won by the core.
- No requests → `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, no grants.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core data port, the external master and the data
// memory, as seen by dmem_arbiter. The arbiter uses the slave view.
interface dmem_arbiter_if;
  // Core side
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_gnt;
  logic        cpu_stall;

  // External master side
  logic        ext_req;
  logic        ext_we;
  logic        ext_lock;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata;
  logic        ext_gnt;

  // Memory side
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_gnt, cpu_stall,
    output ext_rdata, ext_gnt,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_gnt, cpu_stall,
    input  ext_rdata, ext_gnt,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: core vs. external master,
// round-robin with a bounded external lock. Grant and muxing are combinational.
module dmem_arbiter #(
  parameter int MAX_LOCK = 8
) (
  input  logic         clk,
  input  logic         reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

  state_e      st_q, st_d;
  logic        last_q, last_d;       // 0 = core owned last, 1 = ext owned last
  logic [7:0]  lock_cnt_q, lock_cnt_d;

  logic        cpu_gnt;
  logic        ext_gnt;

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    // Outputs are forced quiet while reset is held, not only after the edge.
    if (!reset) begin
      if (st_q == ST_LOCKED && bus.ext_req) begin
        if (bus.cpu_req && lock_cnt_q == LOCK_LIMIT) begin
          cpu_gnt = 1'b1;
        end else begin
          ext_gnt = 1'b1;
        end
      end else if (bus.cpu_req && bus.ext_req) begin
        if (last_q) begin
          cpu_gnt = 1'b1;
        end else begin
          ext_gnt = 1'b1;
        end
      end else begin
        cpu_gnt = bus.cpu_req;
        ext_gnt = bus.ext_req;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: lock FSM, round-robin pointer, lock counter
  // ---------------------------------------------------------------------------
  always_comb begin
    st_d       = st_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;

    unique case (st_q)
      ST_IDLE: begin
        if (ext_gnt && bus.ext_lock) begin
          st_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!bus.ext_req || cpu_gnt || (ext_gnt && !bus.ext_lock)) begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase

    if (cpu_gnt) begin
      last_d = 1'b0;
    end else if (ext_gnt) begin
      last_d = 1'b1;
    end

    // The counter measures how long the core has waited behind a lock.
    if (st_d != st_q || !bus.cpu_req) begin
      lock_cnt_d = 8'd0;
    end else if (st_q == ST_LOCKED && ext_gnt && lock_cnt_q != 8'hFF) begin
      lock_cnt_d = lock_cnt_q + 8'd1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values of its peers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= ST_IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= 8'd0;
    end else begin
      st_q       <= st_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory mux and requester outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    if (cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (ext_gnt) begin
      bus.mem_we    = bus.ext_we;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.ext_gnt   = ext_gnt;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt & ~reset;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.ext_rdata = bus.mem_rdata;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_one_grant : assert property (@(posedge clk) disable iff (reset)
    !(cpu_gnt && ext_gnt));

  a_lock_bounded : assert property (@(posedge clk) disable iff (reset)
    lock_cnt_q <= LOCK_LIMIT);

  a_grant_needs_req : assert property (@(posedge clk) disable iff (reset)
    (!cpu_gnt || bus.cpu_req) && (!ext_gnt || bus.ext_req));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run compared against a small behavioural model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int MAX_LOCK = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: locked flag, who owned last, how long core waited behind the lock
  bit m_locked;
  bit m_last;
  int m_wait;

  task automatic model_reset();
    m_locked = 1'b0;
    m_last   = 1'b1;
    m_wait   = 0;
  endtask

  function automatic void model_grant(input bit creq, input bit ereq,
                                      output bit cg, output bit eg);
    cg = 1'b0;
    eg = 1'b0;
    if (m_locked && ereq) begin
      if (creq && m_wait >= MAX_LOCK) cg = 1'b1;
      else                            eg = 1'b1;
    end else if (creq && ereq) begin
      if (m_last) cg = 1'b1;
      else        eg = 1'b1;
    end else begin
      cg = creq;
      eg = ereq;
    end
  endfunction

  task automatic model_advance(input bit cg, input bit eg, input bit creq, input bit elock);
    bit stay_locked;
    stay_locked = eg && elock;
    m_wait   = (m_locked && stay_locked && creq) ? m_wait + 1 : 0;
    m_locked = stay_locked;
    if (cg)      m_last = 1'b0;
    else if (eg) m_last = 1'b1;
  endtask

  task automatic drive(input bit creq, input bit cwe, input logic [31:0] caddr,
                       input logic [31:0] cwd, input bit ereq, input bit ewe,
                       input bit elock, input logic [31:0] eaddr,
                       input logic [31:0] ewd, input logic [31:0] rdata);
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.ext_req   = ereq;
    bus.ext_we    = ewe;
    bus.ext_lock  = elock;
    bus.ext_addr  = eaddr;
    bus.ext_wdata = ewd;
    bus.mem_rdata = rdata;
  endtask

  task automatic tick(input bit cg, input bit eg, input bit creq, input bit elock);
    @(posedge clk);
    model_advance(cg, eg, creq, elock);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [3:0] act;
    reset = 1'b1;
    drive(1, 1, 32'h44, 32'h11, 1, 1, 1, 32'h88, 32'h22, 32'h0);
    repeat (2) @(negedge clk);
    act = {bus.cpu_gnt, bus.ext_gnt, bus.cpu_stall, bus.mem_we};
    n_checks++;
    if (act !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got gnt/gnt/stall/we=%b expected 0000", act);
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mem: got addr=%h wdata=%h expected 0/0", bus.mem_addr, bus.mem_wdata);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_core_load();
    logic [3:0] act;
    drive(1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'hDEADBEEF);
    #1;
    act = {bus.cpu_gnt, bus.ext_gnt, bus.cpu_stall, bus.mem_we};
    n_checks++;
    if (act !== 4'b1000) begin
      n_fail++;
      $display("FAIL core_load_ctrl: got %b expected 1000", act);
    end
    n_checks++;
    if (bus.cpu_rdata !== 32'hDEADBEEF || bus.mem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL core_load_data: got rdata=%h addr=%h expected deadbeef/10",
               bus.cpu_rdata, bus.mem_addr);
    end
    tick(1, 0, 1, 0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_round_robin();
    logic [31:0] caddr [4] = '{32'h100, 32'h104, 32'h104, 32'h108};
    logic [31:0] eaddr [4] = '{32'h20, 32'h20, 32'h24, 32'h24};
    bit          ewe   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit          exp_cg[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  act, exp_v;
    logic [31:0] exp_addr;
    // One ext-only access first so the core wins the first contest
    drive(0, 0, 0, 0, 1, 0, 0, 32'h40, 0, 32'h1);
    #1;
    n_checks++;
    if (bus.ext_gnt !== 1'b1 || bus.ext_rdata !== 32'h1) begin
      n_fail++;
      $display("FAIL rr_ext_only: got gnt=%b rdata=%h expected 1/1", bus.ext_gnt, bus.ext_rdata);
    end
    tick(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, caddr[k], 32'h0, 1, ewe[k], 0, eaddr[k], ewe[k] ? 32'h55 : 32'h0, 32'hC0DE_0000 + k);
      #1;
      exp_v    = {exp_cg[k], !exp_cg[k], !exp_cg[k], k == 1};
      exp_addr = exp_cg[k] ? caddr[k] : eaddr[k];
      act      = {bus.cpu_gnt, bus.ext_gnt, bus.cpu_stall, bus.mem_we};
      n_checks++;
      if (act !== exp_v || bus.mem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: got ctrl=%b addr=%h expected ctrl=%b addr=%h",
                 k + 1, act, bus.mem_addr, exp_v, exp_addr);
      end
      if (k == 1) begin
        n_checks++;
        if (bus.mem_wdata !== 32'h55) begin
          n_fail++;
          $display("FAIL rr_ext_store: got wdata=%h expected 55", bus.mem_wdata);
        end
      end
      tick(exp_cg[k], !exp_cg[k], 1, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_lock_break();
    bit creq  [7] = '{0, 1, 1, 1, 1, 1, 1};
    bit elock [7] = '{1, 1, 1, 1, 1, 0, 0};
    bit exp_cg[7] = '{0, 0, 0, 0, 1, 0, 1};
    logic [3:0]  act, exp_v;
    logic [31:0] exp_addr;
    for (int k = 0; k < 7; k++) begin
      drive(creq[k], 0, 32'h300, 0, 1, 0, elock[k], 32'h200, 0, 32'h0);
      #1;
      exp_v    = {exp_cg[k], !exp_cg[k], creq[k] && !exp_cg[k], 1'b0};
      exp_addr = exp_cg[k] ? 32'h300 : 32'h200;
      act      = {bus.cpu_gnt, bus.ext_gnt, bus.cpu_stall, bus.mem_we};
      n_checks++;
      if (act !== exp_v || bus.mem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL lock_cycle%0d: got ctrl=%b addr=%h expected ctrl=%b addr=%h",
                 k + 1, act, bus.mem_addr, exp_v, exp_addr);
      end
      tick(exp_cg[k], !exp_cg[k], creq[k], elock[k]);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_lock_release();
    bit creq  [4] = '{0, 1, 1, 1};
    bit elock [4] = '{1, 1, 0, 0};
    bit exp_cg[4] = '{0, 0, 0, 1};
    logic [1:0] act;
    for (int k = 0; k < 4; k++) begin
      drive(creq[k], 0, 32'h500, 0, 1, 0, elock[k], 32'h600, 0, 32'h0);
      #1;
      act = {bus.cpu_gnt, bus.ext_gnt};
      n_checks++;
      if (act !== {exp_cg[k], !exp_cg[k]}) begin
        n_fail++;
        $display("FAIL release_cycle%0d: got gnt=%b expected %b", k + 1, act, {exp_cg[k], !exp_cg[k]});
      end
      tick(exp_cg[k], !exp_cg[k], creq[k], elock[k]);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_lock();
    logic [3:0] act;
    drive(0, 0, 0, 0, 1, 1, 1, 32'h80, 32'hA5A5, 0);
    tick(0, 1, 0, 1);
    drive(1, 0, 32'h90, 0, 1, 1, 1, 32'h84, 32'h5A5A, 0);
    #1;
    act = {bus.cpu_gnt, bus.ext_gnt, bus.cpu_stall, bus.mem_we};
    n_checks++;
    if (act !== 4'b0111) begin
      n_fail++;
      $display("FAIL midlock_pre: got %b expected 0111", act);
    end
    reset = 1'b1;
    #1;
    act = {bus.cpu_gnt, bus.ext_gnt, bus.cpu_stall, bus.mem_we};
    n_checks++;
    if (act !== 4'b0000 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL midlock_async: got ctrl=%b addr=%h wdata=%h expected 0000/0/0",
               act, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive(1, 0, 32'h90, 0, 1, 0, 0, 32'h84, 0, 0);
    #1;
    n_checks++;
    if ({bus.cpu_gnt, bus.ext_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset_contest: got gnt=%b expected 10", {bus.cpu_gnt, bus.ext_gnt});
    end
    tick(1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_idle();
    logic [3:0] act;
    drive(0, 1, 32'hFFFF0000, 32'h1234, 0, 1, 1, 32'hABCD, 32'h9999, 32'h77);
    #1;
    act = {bus.cpu_gnt, bus.ext_gnt, bus.cpu_stall, bus.mem_we};
    n_checks++;
    if (act !== 4'b0000 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL idle: got ctrl=%b addr=%h wdata=%h expected 0000/0/0",
               act, bus.mem_addr, bus.mem_wdata);
    end
    tick(0, 0, 0, 1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    bit          creq, cwe, ereq, ewe, elock, cg, eg;
    logic [31:0] caddr, cwd, eaddr, ewd, rdata, exp_addr, exp_wd;
    logic [3:0]  act, exp_v;
    for (int n = 0; n < 400; n++) begin
      creq  = $urandom_range(0, 3) != 0;
      ereq  = $urandom_range(0, 3) != 0;
      elock = $urandom_range(0, 2) != 0;
      cwe   = $urandom_range(0, 1) == 1;
      ewe   = $urandom_range(0, 1) == 1;
      caddr = $urandom;
      cwd   = $urandom;
      eaddr = $urandom;
      ewd   = $urandom;
      rdata = $urandom;
      drive(creq, cwe, caddr, cwd, ereq, ewe, elock, eaddr, ewd, rdata);
      model_grant(creq, ereq, cg, eg);
      exp_addr = cg ? caddr : (eg ? eaddr : 32'd0);
      exp_wd   = cg ? cwd   : (eg ? ewd   : 32'd0);
      exp_v    = {cg, eg, creq && !cg, cg ? cwe : (eg ? ewe : 1'b0)};
      #1;
      act = {bus.cpu_gnt, bus.ext_gnt, bus.cpu_stall, bus.mem_we};
      n_checks++;
      if (act !== exp_v || bus.mem_addr !== exp_addr || bus.mem_wdata !== exp_wd) begin
        n_fail++;
        $display("FAIL rand%0d: got ctrl=%b addr=%h wdata=%h expected ctrl=%b addr=%h wdata=%h",
                 n, act, bus.mem_addr, bus.mem_wdata, exp_v, exp_addr, exp_wd);
      end
      n_checks++;
      if (bus.cpu_rdata !== rdata || bus.ext_rdata !== rdata) begin
        n_fail++;
        $display("FAIL rand_rdata%0d: got cpu=%h ext=%h expected %h",
                 n, bus.cpu_rdata, bus.ext_rdata, rdata);
      end
      tick(cg, eg, creq, elock);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_core_load();
    test_round_robin();
    test_lock_break();
    test_lock_release();
    test_reset_mid_lock();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
